// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a 16x4 dual-port FIFO RAM.
// Converts push/pop requests into RAM port controls and tracks status flags.
module fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              re_b,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Flags decode only from the count register, so they never glitch on inputs.
  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_empty = (count <= AE_C);
    almost_full  = (count >= AF_C);
  end

  // A push into a full FIFO is allowed when a pop frees the slot on the same edge.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  always_comb begin
    data_a = data_in;
    addr_a = wr_ptr;
    we_a   = push_ok;
    addr_b = rd_ptr;
    re_b   = pop_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      rd_valid  <= pop_ok;
      overflow  <= (push & ~push_ok) | (overflow & ~clr_err);
      underflow <= (pop & ~pop_ok) | (underflow & ~clr_err);
    end
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer, occupancy and flag controller for the 16x4 dual-port FIFO storage RAM in the TLP buffering path. Turns upstream push/pop requests into RAM port controls: write address, write enable, read address and read enable. Tracks occupancy and status flags. Produces a read-valid strobe aligned with the RAM's registered read data, which arrives one cycle after the read enable.

Parameters:
DATA_W, 4, width of data passed through to the RAM write port
ADDR_W, 4, RAM address width; depth = 2**ADDR_W (16)
AF_LVL, 12, almost_full asserted when count >= AF_LVL
AE_LVL, 2, almost_empty asserted when count <= AE_LVL

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
push  in  1  write request
data_in  in  DATA_W  write data
pop  in  1  read request
clr_err  in  1  synchronous clear of sticky error flags
data_a  out  DATA_W  RAM write data (combinational = data_in)
addr_a  out  ADDR_W  RAM write address (= wr_ptr register)
we_a  out  1  RAM write enable (combinational = push_ok)
addr_b  out  ADDR_W  RAM read address (= rd_ptr register)
re_b  out  1  RAM read enable (combinational = pop_ok)
rd_valid  out  1  RAM q_b holds popped word this cycle
count  out  ADDR_W+1  occupancy, 0..16
empty  out  1  count == 0
full  out  1  count == 16
almost_empty  out  1  count <= AE_LVL
almost_full  out  1  count >= AF_LVL
overflow  out  1  sticky: push refused
underflow  out  1  sticky: pop refused

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is asynchronous and active-high. Both are fixed.
  - While reset is high: wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0.
  - Flag outputs during reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset mid-operation discards all contents. Any in-flight rd_valid drops immediately.
- Acceptance (combinational):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - Push while full with a simultaneous accepted pop is allowed. The RAM returns the old word at the shared address, because its read and write are both nonblocking on the same edge.
  - Push and pop while empty: push accepted, pop refused. The word is not bypassed.
- Pointer update on rising edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - Both wrap modulo 16 (15 -> 0) with no extra logic.
- Occupancy update: count += push_ok - pop_ok.
  - Accepted push and pop in the same cycle leave count unchanged.
  - count never exceeds 16 and never goes below 0.
- Flags:
  - All flags decode combinationally from the count register, so they change the cycle after the accepting edge.
  - Flags are glitch-free relative to clk.
- Read latency:
  - rd_valid <= pop_ok, i.e. high exactly one cycle after the re_b cycle, aligned with RAM q_b.
  - Back-to-back pops give back-to-back rd_valid.
- Errors:
  - overflow sets on push & ~push_ok. underflow sets on pop & ~pop_ok.
  - Both are sticky until clr_err=1 at a clock edge.
  - If set and clr_err occur in the same cycle, set wins.
  - Refused requests never alter pointers, count or RAM.
- Parameter legality: AF_LVL and AE_LVL must lie in 0..16. No other checks.

Test Plan:
1. Reset, then 16 pushes of data 0..F with no pops.
   - count steps 0 -> 16; full=1 after the 16th edge; almost_full=1 once count reaches 12.
   - addr_a sequence 0..F, then wr_ptr wraps to 0.
2. From full, a 17th push with pop=0.
   - we_a=0, overflow=1, count stays 16.
   - clr_err pulse clears overflow the next cycle.
3. Drain 16 pops.
   - addr_b 0..F; rd_valid high one cycle after each re_b; q_b reads 0..F in order.
   - empty=1 after the last edge.
   - An extra pop gives re_b=0 and underflow=1.
4. Push+pop every cycle for 40 cycles starting at count=5.
   - count holds 5; both pointers wrap twice.
   - Data emerges in FIFO order with 5-entry lag.
5. Simultaneous push+pop at count=0 -> push accepted, pop refused, underflow=1, count=1. Simultaneous push+pop at count=16 -> both accepted, count stays 16, overflow stays 0.
6. Assert reset asynchronously between edges at count=9 with rd_valid=1.
   - All outputs return to reset values before the next edge.
   - The first push after release writes to address 0.
